line_buffer_sequencer: RTL and testbench

//  Sequences the per-fmap line-buffer datapath (SRAM row bank + column shift arrays).

---
 rtl/line_buffer_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_line_buffer_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_sequencer.sv
// Line-buffer sequencer: tracks the raster position of incoming pixels, rotates the SRAM write row
// and emits window-valid strobes 2 pipeline cycles after the accept. Optional stats: LINE_BUF_SEQ_STATS_EN.
module line_buffer_sequencer #(
  parameter int KER_SIZE_X   = 3,
  parameter int KER_SIZE_Y   = 3,
  parameter int STRIDE_X     = 1,
  parameter int STRIDE_Y     = 1,
  parameter int IMAGE_SIZE_X = 32,
  parameter int IMAGE_SIZE_Y = 32,
  parameter int ADDR_WIDTH   = $clog2(IMAGE_SIZE_X),
  parameter int ROW_WIDTH    = $clog2(IMAGE_SIZE_Y)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [KER_SIZE_Y:0]   write_en,
  output logic [KER_SIZE_Y:0]   read_en,
  output logic [2:0]            col_ptr,
  output logic [2:0]            init_col_ptr,
  output logic                  row_is_complete,
  output logic                  frame_done,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] win_col,
  output logic [ROW_WIDTH-1:0]  win_row
`ifdef LINE_BUF_SEQ_STATS_EN
  ,output logic [15:0]          win_count
`endif
);

  localparam int NROWS = KER_SIZE_Y + 1;
  localparam int WR_W  = $clog2(NROWS);

  localparam logic [ADDR_WIDTH-1:0] COL_LAST     = ADDR_WIDTH'(IMAGE_SIZE_X - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_KX1      = ADDR_WIDTH'(KER_SIZE_X - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_LAST     = ROW_WIDTH'(IMAGE_SIZE_Y - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_KY1      = ROW_WIDTH'(KER_SIZE_Y - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_FILL_END = ROW_WIDTH'(KER_SIZE_Y - 2);
  localparam logic [WR_W-1:0]       WR_LAST      = WR_W'(KER_SIZE_Y);
  localparam logic [2:0]            CP_LAST      = 3'(KER_SIZE_X - 1);
  localparam logic [1:0]            SX_LAST      = 2'(STRIDE_X - 1);
  localparam logic [1:0]            SY_LAST      = 2'(STRIDE_Y - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [WR_W-1:0]       wr_row_q, wr_row_d;
  logic [2:0]            cp_q, cp_d;
  logic [2:0]            icp_q, icp_d;
  logic [1:0]            sx_q, sx_d;
  logic [1:0]            sy_q, sy_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [ADDR_WIDTH-1:0] s1_col_q, s1_col_d;
  logic [ROW_WIDTH-1:0]  s1_row_q, s1_row_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [ADDR_WIDTH-1:0] s2_col_q, s2_col_d;
  logic [ROW_WIDTH-1:0]  s2_row_q, s2_row_d;

  logic             accept, col_last, row_last, win_hit;
  logic [NROWS-1:0] wr_onehot;

  assign accept    = valid & ~stall & ~flush;
  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign wr_onehot = {{(NROWS-1){1'b0}}, 1'b1} << wr_row_q;
  // Stride phases are tracked by counters so the window test needs no modulo hardware.
  assign win_hit   = accept & (state_q == STREAM) & (col_q >= COL_KX1)
                   & (sx_q == 2'd0) & (sy_q == 2'd0);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    wr_row_d = wr_row_q;
    cp_d     = cp_q;
    icp_d    = icp_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    s1_vld_d = s1_vld_q;
    s1_col_d = s1_col_q;
    s1_row_d = s1_row_q;
    s2_vld_d = s2_vld_q;
    s2_col_d = s2_col_q;
    s2_row_d = s2_row_q;

    if (flush) begin
      state_d  = IDLE;
      col_d    = '0;
      row_d    = '0;
      wr_row_d = '0;
      cp_d     = '0;
      icp_d    = '0;
      sx_d     = '0;
      sy_d     = '0;
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else if (!stall) begin
      s2_vld_d = s1_vld_q;
      s2_col_d = s1_col_q;
      s2_row_d = s1_row_q;
      s1_vld_d = win_hit;
      s1_col_d = col_q - COL_KX1;
      s1_row_d = row_q - ROW_KY1;

      if (accept) begin
        unique case (state_q)
          IDLE:    state_d = FILL;
          FILL:    if (col_last && row_q == ROW_FILL_END) state_d = STREAM;
          default: state_d = state_q;
        endcase

        if (col_q >= COL_KX1) sx_d = (sx_q == SX_LAST) ? 2'd0 : sx_q + 2'd1;
        cp_d  = (cp_q == CP_LAST) ? 3'd0 : cp_q + 3'd1;
        icp_d = (icp_q == CP_LAST) ? icp_q : icp_q + 3'd1;
        col_d = col_q + ADDR_WIDTH'(1);

        if (col_last) begin
          col_d    = '0;
          cp_d     = '0;
          icp_d    = '0;
          sx_d     = '0;
          row_d    = row_q + ROW_WIDTH'(1);
          wr_row_d = (wr_row_q == WR_LAST) ? '0 : wr_row_q + WR_W'(1);
          if (row_q >= ROW_KY1) sy_d = (sy_q == SY_LAST) ? 2'd0 : sy_q + 2'd1;
          else                  sy_d = 2'd0;
          if (row_last) begin
            state_d = IDLE;
            row_d   = '0;
            sy_d    = 2'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      wr_row_q <= '0;
      cp_q     <= '0;
      icp_q    <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      s1_vld_q <= 1'b0;
      s1_col_q <= '0;
      s1_row_q <= '0;
      s2_vld_q <= 1'b0;
      s2_col_q <= '0;
      s2_row_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values of its peers.
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      wr_row_q <= wr_row_d;
      cp_q     <= cp_d;
      icp_q    <= icp_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      s1_vld_q <= s1_vld_d;
      s1_col_q <= s1_col_d;
      s1_row_q <= s1_row_d;
      s2_vld_q <= s2_vld_d;
      s2_col_q <= s2_col_d;
      s2_row_q <= s2_row_d;
    end
  end

  // A held window is shown once, in the first cycle the pipeline is free to advance.
  assign ready           = s2_vld_q & ~stall & ~flush;
  assign win_col         = ready ? s2_col_q : '0;
  assign win_row         = ready ? s2_row_q : '0;
  assign addr            = col_q;
  assign write_en        = accept ? wr_onehot : '0;
  assign read_en         = (accept && state_q == STREAM) ? ~wr_onehot : '0;
  assign col_ptr         = cp_q;
  assign init_col_ptr    = icp_q;
  assign row_is_complete = accept & col_last;
  assign frame_done      = accept & col_last & row_last;

`ifdef LINE_BUF_SEQ_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Windows are counted when detected so the total is final at frame_done.
  always_comb begin
    cnt_d = cnt_q;
    if (flush)       cnt_d = '0;
    else if (accept) cnt_d = ((state_q == IDLE) ? 16'd0 : cnt_q) + 16'(win_hit);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign win_count = cnt_q;
`endif

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Self-checking bench: stride-1 and stride-2 instances on an 8x4 image, a vector table for
// the first cycles, directed frame/flush/reset sequences and randomized valid/stall gaps.
module tb_line_buffer_sequencer;
  localparam int KX = 3, KY = 3, W = 8, H = 4, NR = KY + 1;
  localparam int AW = $clog2(W), RW = $clog2(H);

  logic clk = 1'b0, rstn = 1'b0, valid = 1'b0, stall = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] addr_a, addr_b, wcol_a, wcol_b;
  logic [NR-1:0] we_a, we_b, re_a, re_b;
  logic [2:0]    cp_a, cp_b, icp_a, icp_b;
  logic          rc_a, rc_b, fd_a, fd_b, rdy_a, rdy_b;
  logic [RW-1:0] wrow_a, wrow_b;
`ifdef LINE_BUF_SEQ_STATS_EN
  logic [15:0]   wcnt_a, wcnt_b;
`endif

  line_buffer_sequencer #(.KER_SIZE_X(KX), .KER_SIZE_Y(KY), .STRIDE_X(1), .STRIDE_Y(1),
                          .IMAGE_SIZE_X(W), .IMAGE_SIZE_Y(H)) dut_a (
    .clk(clk), .rstn(rstn), .valid(valid), .stall(stall), .flush(flush),
    .addr(addr_a), .write_en(we_a), .read_en(re_a), .col_ptr(cp_a), .init_col_ptr(icp_a),
    .row_is_complete(rc_a), .frame_done(fd_a), .ready(rdy_a), .win_col(wcol_a), .win_row(wrow_a)
`ifdef LINE_BUF_SEQ_STATS_EN
    , .win_count(wcnt_a)
`endif
  );

  line_buffer_sequencer #(.KER_SIZE_X(KX), .KER_SIZE_Y(KY), .STRIDE_X(2), .STRIDE_Y(2),
                          .IMAGE_SIZE_X(W), .IMAGE_SIZE_Y(H)) dut_b (
    .clk(clk), .rstn(rstn), .valid(valid), .stall(stall), .flush(flush),
    .addr(addr_b), .write_en(we_b), .read_en(re_b), .col_ptr(cp_b), .init_col_ptr(icp_b),
    .row_is_complete(rc_b), .frame_done(fd_b), .ready(rdy_b), .win_col(wcol_b), .win_row(wrow_b)
`ifdef LINE_BUF_SEQ_STATS_EN
    , .win_count(wcnt_b)
`endif
  );

  typedef struct { int col; int row; int age; } win_t;
  typedef struct { logic v, s, f; logic [NR-1:0] we, re; logic [AW-1:0] addr; } vec_t;

  int   n_chk = 0, n_pass = 0;
  int   idx, wr, cyc = 0;
  win_t wq [2][$];
  int   rdy_cnt [2];
  int   cnt_exp [2];
  int   fd_cnt, t22 = -1, t_rdy = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit is_win(input int c, input int r, input int s);
    return r >= KY-1 && c >= KX-1 && ((c-KX+1) % s == 0) && ((r-KY+1) % s == 0);
  endfunction

  task automatic model_clear();
    idx = 0;
    wr  = 0;
    for (int k = 0; k < 2; k++) begin
      wq[k].delete();
      cnt_exp[k] = 0;
    end
  endtask

  task automatic clear_counts();
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    fd_cnt     = 0;
  endtask

  // One clock cycle: drive, compare against the model just before the edge, advance the model.
  task automatic step(input bit v, input bit s, input bit f);
    bit            acc, er;
    int            c, r;
    logic [NR-1:0] ewe, ere;
    logic          rdy;
    logic [31:0]   wc, wrr, wcnt;
    string         sfx;
    win_t          w;
    @(negedge clk);
    valid = v; stall = s; flush = f;
    #1;
    cyc++;
    acc = v && !s && !f;
    c   = idx % W;
    r   = idx / W;
    ewe = '0;
    if (acc) ewe[wr] = 1'b1;
    ere = (acc && r >= KY-1) ? ~ewe : '0;
    check("write_en", 32'(we_a), 32'(ewe));
    check("read_en", 32'(re_a), 32'(ere));
    check("row_is_complete", 32'(rc_a), 32'(acc && c == W-1));
    check("frame_done", 32'(fd_a), 32'(acc && idx == W*H-1));
    if (acc) begin
      check("addr", 32'(addr_a), 32'(c));
      check("col_ptr", 32'(cp_a), 32'(c % KX));
      check("init_col_ptr", 32'(icp_a), 32'((c < KX-1) ? c : KX-1));
      if (c == 2 && r == 2 && t22 < 0) t22 = cyc;
    end
    if (fd_a) fd_cnt++;
    for (int k = 0; k < 2; k++) begin
      sfx  = (k == 0) ? "_a" : "_b";
      rdy  = (k == 0) ? rdy_a : rdy_b;
      wc   = (k == 0) ? 32'(wcol_a) : 32'(wcol_b);
      wrr  = (k == 0) ? 32'(wrow_a) : 32'(wrow_b);
      wcnt = 0;
`ifdef LINE_BUF_SEQ_STATS_EN
      wcnt = (k == 0) ? 32'(wcnt_a) : 32'(wcnt_b);
      check({"win_count", sfx}, wcnt, 32'(cnt_exp[k]));
`endif
      er = wq[k].size() > 0 && wq[k][0].age == 1 && !s && !f;
      check({"ready", sfx}, 32'(rdy), 32'(er));
      if (rdy === 1'b1) begin
        rdy_cnt[k]++;
        if (k == 0 && t_rdy < 0) t_rdy = cyc;
      end
      if (er) begin
        check({"win_col", sfx}, wc, 32'(wq[k][0].col));
        check({"win_row", sfx}, wrr, 32'(wq[k][0].row));
        void'(wq[k].pop_front());
      end
      if (f) wq[k].delete();
      else if (!s) for (int j = 0; j < wq[k].size(); j++) wq[k][j].age++;
      if (f) cnt_exp[k] = 0;
      else if (acc) begin
        if (idx == 0) cnt_exp[k] = 0;
        if (is_win(c, r, k + 1)) begin
          cnt_exp[k]++;
          w.col = c - KX + 1; w.row = r - KY + 1; w.age = 0;
          wq[k].push_back(w);
        end
      end
    end
    if (f) begin
      idx = 0;
      wr  = 0;
    end else if (acc) begin
      if (c == W-1) wr = (wr + 1) % NR;
      idx = (idx + 1) % (W*H);
    end
  endtask

  task automatic run_pixels(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("rst write_en", 32'(we_a), 0);
    check("rst read_en", 32'(re_a), 0);
    check("rst addr", 32'(addr_a), 0);
    check("rst ptrs", {29'd0, cp_a | icp_a}, 0);
    check("rst pulses", {29'd0, rc_a, fd_a, rdy_a | rdy_b}, 0);
    check("rst window", 32'(wcol_a) | 32'(wrow_a), 0);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  initial begin
    vec_t tbl [6];
    int   acc_n;
    bit   v, s;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 3'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 3'd1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'd1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 3'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 3'd1};

    model_clear();
    clear_counts();
    do_reset();

    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].f);
      check($sformatf("tbl%0d write_en", i), 32'(we_a), 32'(tbl[i].we));
      check($sformatf("tbl%0d read_en", i), 32'(re_a), 32'(tbl[i].re));
      check($sformatf("tbl%0d addr", i), 32'(addr_a), 32'(tbl[i].addr));
    end
    step(1'b0, 1'b0, 1'b1);

    // Continuous frame: 12 windows at stride 1, 3 at stride 2, exact 2-cycle latency.
    clear_counts();
    t22 = -1; t_rdy = -1;
    run_pixels(W*H);
    drain();
    check("T1 windows", 32'(rdy_cnt[0]), 12);
    check("T2 windows", 32'(rdy_cnt[1]), 3);
    check("T1 frame_done", 32'(fd_cnt), 1);
    check("T1 latency", 32'(t_rdy - t22), 2);
`ifdef LINE_BUF_SEQ_STATS_EN
    check("T6 win_count", 32'(wcnt_a), 12);
`endif

    // Random valid gaps and stalls.
    clear_counts();
    acc_n = 0;
    for (int i = 0; i < 2000 && acc_n < W*H; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0);
      step(v, s, 1'b0);
      if (v && !s) acc_n++;
    end
    check("T3 pixels accepted", 32'(acc_n), 32'(W*H));
    for (int i = 0; i < 12; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    drain();
    check("T3 windows", 32'(rdy_cnt[0]), 12);
    check("T3 windows stride2", 32'(rdy_cnt[1]), 3);

    // Flush at pixel (4,2) with windows in flight, then a clean frame.
    run_pixels(2*W + 4);
    step(1'b1, 1'b0, 1'b1);
    clear_counts();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    check("T4 no ready after flush", 32'(rdy_cnt[0] + rdy_cnt[1]), 0);
`ifdef LINE_BUF_SEQ_STATS_EN
    check("T6 win_count flush", 32'(wcnt_a), 0);
`endif
    run_pixels(W*H);
    drain();
    check("T4 windows", 32'(rdy_cnt[0]), 12);

    // Reset mid-row, then two back-to-back frames.
    run_pixels(W + 3);
    do_reset();
    clear_counts();
    run_pixels(2*W*H);
    drain();
    check("T5 windows", 32'(rdy_cnt[0]), 24);
    check("T5 windows stride2", 32'(rdy_cnt[1]), 6);
    check("T5 frame_done", 32'(fd_cnt), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
